press_conditioner: RTL and testbench

Conditions one raw player push-button into clean control signals for the game logic. It synchronises the asynchronous key input and debounces it with a press/release state machine. It emits a single-cycle `press` pulse per physical press, which is the signal the game-start latch and the bird-flap logic consume, plus a debounced `held` level. One instance sits between each board KEY pin and the game core.

---
 rtl/press_conditioner.sv | 107 ++++++++++
 tb/tb_press_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/press_conditioner.sv
// Push-button conditioner: polarity normalisation, two-flop synchroniser and a
// press/release debounce FSM producing a one-cycle press pulse and a held level.
module press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic press,
  output logic held
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             press_q, press_d;
  logic             held_q, held_d;
  logic             k;

  // k = 1 means pushed, whatever the board polarity
  assign k = key_in ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      s1_q    <= k;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        // A re-push inside the window returns to HELD without a new pulse
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign press = press_q;
  assign held  = held_q;

endmodule

// File: tb/tb_press_conditioner.sv
// Bench for press_conditioner: run-length debounce reference model, directed
// scenarios with literal expectations, then randomized bursts and resets.
module tb_press_conditioner;

  localparam int D = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic key_in = 1'b1;
  logic key2;
  logic press, held, press2, held2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Second instance is active-high and sees the complementary raw level,
  // so it must behave identically to the first.
  assign key2 = ~key_in;

  press_conditioner #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .press(press), .held(held)
  );

  press_conditioner #(.DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .reset(reset), .key_in(key2), .press(press2), .held(held2)
  );

  // Reference: the debounced level toggles once the synchronised input has
  // disagreed with it for D+1 consecutive samples; toggling to pushed pulses.
  bit m_s1, m_s2, m_held, m_press;
  int m_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_held = 0; m_press = 0; m_run = 0;
    end else begin
      m_press = 0;
      if (m_s2 != m_held) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
        m_held  = !m_held;
        m_press = m_held;
        m_run   = 0;
      end
      m_s2 = m_s1;
      m_s1 = !key_in;
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_press", press, m_press);
    chk("model_held", held, m_held);
    chk("model_press_ah", press2, m_press);
    chk("model_held_ah", held2, m_held);
  end

  task automatic hold_key(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      key_in = v;
      @(negedge clk);
    end
  endtask

  initial begin
    logic bounce [10];
    logic glitch [8];
    int   pulses;
    bounce = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    glitch = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_press", press, 1'b0);
    chk("reset_held", held, 1'b0);
    reset = 1'b0;
    hold_key(1'b1, 5);

    // Clean press: pulse exactly after edge 6, held from edge 6 on
    key_in = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      chk("clean_press", press, i == 6);
      chk("clean_held", held, i >= 6);
      chk("clean_press_ah", press2, i == 6);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (press) pulses++;
    end
    chk("no_autorepeat", pulses != 0, 1'b0);

    // Release: held drops after edge 6
    key_in = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      chk("release_held", held, i < 6);
      chk("release_press", press, 1'b0);
    end

    // Re-push, then a release glitch; held stays until 6 edges after the last 0->1
    hold_key(1'b0, 12);
    chk("repush_held", held, 1'b1);
    for (int i = 0; i <= 11; i++) begin
      key_in = (i < 8) ? glitch[i] : 1'b1;
      @(negedge clk);
      chk("glitch_held", held, i < 9);
      chk("glitch_press", press, 1'b0);
    end
    hold_key(1'b1, 5);

    // Bounce on press: first burst rejected, pulse after edge 10
    for (int i = 0; i <= 12; i++) begin
      key_in = (i < 10) ? bounce[i] : 1'b0;
      @(negedge clk);
      chk("bounce_press", press, i == 10);
    end
    hold_key(1'b1, 12);

    // Async reset with a pulse in flight
    key_in = 1'b0;
    repeat (7) @(negedge clk);
    chk("inflight_press", press, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_press", press, 1'b0);
    chk("async_held", held, 1'b0);
    key_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_hold_press", press, 1'b0);
      chk("reset_hold_held", held, 1'b0);
      chk("reset_hold_ah", press2 | held2, 1'b0);
    end
    reset = 1'b0;
    hold_key(1'b1, 3);

    // Async reset in PRESS_WAIT (cnt = 2), key still pushed across deassertion
    key_in = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("pw_reset_press", press, 1'b0);
    chk("pw_reset_held", held, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      chk("post_reset_press", press, i == 6);
      chk("post_reset_held", held, i >= 6);
    end

    // Randomized bursts with occasional asynchronous resets
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        #($urandom_range(1, 4)) reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      hold_key(1'($urandom_range(0, 1)), $urandom_range(1, 9));
    end
    hold_key(1'b1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
